// File: rtl/multiplicacion.sv
// multiplicacion: 2-stage unsigned WIDTH x WIDTH multiplier built from shift-add partial products.
// Optional MULT_SATURATE_EN: saturate to all ones on overflow and drive the desborde output.

module multiplicacion_pp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int SHIFT = 0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [CHUNK-1:0] bs_i,
`ifdef MULT_SATURATE_EN
    output logic             lost_o,
`endif
    output logic [WIDTH-1:0] pp_o
);
`ifdef MULT_SATURATE_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    logic [AW-1:0] acc;

    // Accumulate a shifted by each set bit of this slice of b
    always_comb begin
        acc = '0;
        for (int j = 0; j < CHUNK; j++) begin
            if (bs_i[j]) acc = acc + (AW'(a_i) << (SHIFT + j));
        end
    end

    assign pp_o = acc[WIDTH-1:0];
`ifdef MULT_SATURATE_EN
    assign lost_o = |acc[AW-1:WIDTH];
`endif
endmodule

module multiplicacion #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             enable,
`ifdef MULT_SATURATE_EN
    output logic             desborde,
`endif
    output logic [WIDTH-1:0] salida,
    output logic             valido
);
    localparam int NPP = WIDTH / CHUNK;
`ifdef MULT_SATURATE_EN
    localparam int SW = WIDTH + $clog2(NPP) + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [NPP-1:0][WIDTH-1:0] pp_d, pp_q;
    logic                      en_q;
    logic [SW-1:0]             sum;
    logic [WIDTH-1:0]          salida_d, salida_q;
    logic                      valido_d, valido_q;
`ifdef MULT_SATURATE_EN
    logic [NPP-1:0]            lost_d;
    logic                      ovf_q;
    logic                      desborde_d, desborde_q;
`endif

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        multiplicacion_pp #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SHIFT(i * CHUNK)) u_pp (
            .a_i  (a),
            .bs_i (b[i*CHUNK +: CHUNK]),
`ifdef MULT_SATURATE_EN
            .lost_o (lost_d[i]),
`endif
            .pp_o (pp_d[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pp_q <= '0;
            en_q <= 1'b0;
`ifdef MULT_SATURATE_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            pp_q <= pp_d;
            en_q <= enable;
`ifdef MULT_SATURATE_EN
            ovf_q <= |lost_d;
`endif
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NPP; i++) sum = sum + SW'(pp_q[i]);
    end

    always_comb begin
        salida_d = en_q ? sum[WIDTH-1:0] : '0;
        valido_d = en_q;
`ifdef MULT_SATURATE_EN
        // Overflow is either a bit shifted out of a partial product or a carry out of the sum
        desborde_d = en_q && (ovf_q || (|sum[SW-1:WIDTH]));
        if (desborde_d) salida_d = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            salida_q <= '0;
            valido_q <= 1'b0;
`ifdef MULT_SATURATE_EN
            desborde_q <= 1'b0;
`endif
        end else begin
            salida_q <= salida_d;
            valido_q <= valido_d;
`ifdef MULT_SATURATE_EN
            desborde_q <= desborde_d;
`endif
        end
    end

    assign salida = salida_q;
    assign valido = valido_q;
`ifdef MULT_SATURATE_EN
    assign desborde = desborde_q;
`endif
endmodule

// File: tb/tb_multiplicacion.sv
// Scoreboard bench for multiplicacion: expected results queued at drive time, compared as they emerge.
// Covers wrap-around and, with MULT_SATURATE_EN, saturation/desborde.

module tb_multiplicacion;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        enable = 1'b0;
    logic [31:0] salida;
    logic        valido;
`ifdef MULT_SATURATE_EN
    logic        desborde;
`endif

    typedef struct packed {
        logic        v;
        logic [31:0] s;
        logic        d;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    multiplicacion #(.WIDTH(32), .CHUNK(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .enable (enable),
`ifdef MULT_SATURATE_EN
        .desborde (desborde),
`endif
        .salida (salida),
        .valido (valido)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic ev);
        logic [63:0] p;
        p = {32'b0, av} * {32'b0, bv};
        if (!ev) return '{1'b0, 32'h0, 1'b0};
`ifdef MULT_SATURATE_EN
        if (|p[63:32]) return '{1'b1, 32'hFFFF_FFFF, 1'b1};
`endif
        return '{1'b1, p[31:0], 1'b0};
    endfunction

    task automatic drive(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic ev);
        exp_t e;
        a = av; b = bv; enable = ev;
        sb.push_back(model(av, bv, ev));
        @(posedge clk); #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            chk({tag, ".salida"}, 64'(salida), 64'(e.s));
            chk({tag, ".valido"}, 64'(valido), 64'(e.v));
`ifdef MULT_SATURATE_EN
            chk({tag, ".desborde"}, 64'(desborde), 64'(e.d));
`endif
        end
    endtask

    // One reset clock; in-flight entries are dropped and stage 1 restarts cleared
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        a = 32'h1234_5678; b = 32'h9ABC_DEF0; enable = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".salida"}, 64'(salida), 64'h0);
        chk({tag, ".valido"}, 64'(valido), 64'h0);
`ifdef MULT_SATURATE_EN
        chk({tag, ".desborde"}, 64'(desborde), 64'h0);
`endif
        rst_n = 1'b1;
        sb.delete();
        sb.push_back('{1'b0, 32'h0, 1'b0});
    endtask

    initial begin
        do_reset("rst");

        for (int i = 0; i < 10; i++) drive("8x16", 32'd8, 32'd16, 1'b1);
        for (int i = 0; i < 3; i++)  drive("8x16_dis", 32'd8, 32'd16, 1'b0);

        drive("seq0", 32'd20, 32'd100, 1'b1);
        drive("seq1", 32'd34, 32'd122, 1'b1);
        drive("seq2", 32'd34, 32'd122, 1'b0);
        drive("seq3", 32'd34, 32'd122, 1'b1);

        drive("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drive("2p32", 32'h0001_0000, 32'h0001_0000, 1'b1);
        drive("ffff", 32'h0000_FFFF, 32'h0001_0001, 1'b1);
        drive("a0",   32'h0,         32'hDEAD_BEEF, 1'b1);
        drive("b0",   32'hDEAD_BEEF, 32'h0,         1'b1);
        drive("a1",   32'h1,         32'hCAFE_F00D, 1'b1);
        drive("msb",  32'h8000_0000, 32'h1,         1'b1);
        drive("dis",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom();
            rb = (i % 2 == 0) ? 32'($urandom_range(0, 65535)) : $urandom();
            drive("rnd", ra, rb, 1'($urandom_range(0, 1)));
        end

        drive("pre_rst", 32'd8, 32'd16, 1'b1);
        do_reset("mid_rst");
        drive("post_rst", 32'd3, 32'd5, 1'b1);
        drive("post_rst1", 32'd0, 32'd0, 1'b0);
        drive("flush", 32'd0, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
